// File: rtl/ipv4_fib_lookup_arb.sv
// Round-robin sharing of the single IPv4 FIB lookup port among NUM_REQ requesters.
// Results come back in issue order and are steered to their issuer through a tag FIFO.
module ipv4_fib_lookup_arb #(
    parameter int NUM_REQ         = 2,
    parameter int REQ_BITS        = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ*32-1:0] i_req_daddr,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ack,
    output logic [NUM_REQ-1:0]    o_rsp_valid,
    output logic                  o_rsp_nh_found,
    output logic [31:0]           o_rsp_nh,
    output logic [7:0]            o_rsp_tuser,
    input  logic [NUM_REQ-1:0]    i_rsp_rd,
    output logic [31:0]           o_fib_daddr,
    output logic                  o_fib_daddr_valid,
    input  logic                  i_fib_nh_found,
    input  logic [31:0]           i_fib_nh,
    input  logic [7:0]            i_fib_tuser,
    input  logic                  i_fib_valid,
    output logic                  o_fib_rd,
    output logic [2:0]            o_outstanding,
    output logic                  o_err_orphan
);
    localparam int TAG_DEPTH = 4;

    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [31:0]         daddr_q, daddr_d;
    logic                strobe_q, strobe_d;
    logic [REQ_BITS-1:0] ptr_q, ptr_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [1:0]          wr_q, wr_d;
    logic [1:0]          rd_q, rd_d;
    logic                err_q, err_d;
    logic [REQ_BITS-1:0] tag_mem_q [TAG_DEPTH];

    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic                issue;
    logic [REQ_BITS:0]   idx_w;
    logic [REQ_BITS-1:0] grant;
    logic [31:0]         grant_daddr;
    logic [REQ_BITS-1:0] head;
    logic                tag_empty;
    logic                pop;
    logic                orphan;

    // A requester in its ack cycle is masked so a still-high valid cannot win twice.
    always_comb begin
        eligible    = i_req_valid & ~ack_q;
        found       = 1'b0;
        grant       = ptr_q;
        idx_w       = '0;
        grant_daddr = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_w = {1'b0, ptr_q} + (REQ_BITS+1)'(k);
            if (idx_w >= (REQ_BITS+1)'(NUM_REQ)) begin
                idx_w = idx_w - (REQ_BITS+1)'(NUM_REQ);
            end
            if (!found && eligible[idx_w[REQ_BITS-1:0]]) begin
                found = 1'b1;
                grant = idx_w[REQ_BITS-1:0];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == REQ_BITS'(i)) begin
                grant_daddr = i_req_daddr[32*i +: 32];
            end
        end
        issue = found && (cnt_q < 3'(MAX_OUTSTANDING));
    end

    // Outstanding count doubles as the tag FIFO occupancy.
    assign tag_empty = (cnt_q == 3'd0);
    assign head      = tag_mem_q[rd_q];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            o_rsp_valid[i] = i_fib_valid && !tag_empty && (head == REQ_BITS'(i));
        end
    end

    assign pop    = |(i_rsp_rd & o_rsp_valid);
    assign orphan = i_fib_valid && tag_empty;

    always_comb begin
        ack_d    = '0;
        strobe_d = issue;
        daddr_d  = daddr_q;
        ptr_d    = ptr_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        err_d    = err_q | orphan;
        if (issue) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                ack_d[i] = (grant == REQ_BITS'(i));
            end
            daddr_d = grant_daddr;
            ptr_d   = grant;
            wr_d    = wr_q + 2'd1;
        end
        if (pop) begin
            rd_d = rd_q + 2'd1;
        end
        case ({issue, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem_q[wr_q] <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q    <= '0;
            daddr_q  <= '0;
            strobe_q <= 1'b0;
            ptr_q    <= REQ_BITS'(NUM_REQ - 1);
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            daddr_q  <= daddr_d;
            strobe_q <= strobe_d;
            ptr_q    <= ptr_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign o_req_ack         = ack_q;
    assign o_fib_daddr       = daddr_q;
    assign o_fib_daddr_valid = strobe_q;
    assign o_outstanding     = cnt_q;
    assign o_err_orphan      = err_q;
    assign o_fib_rd          = pop | orphan;
    assign o_rsp_nh_found    = i_fib_nh_found;
    assign o_rsp_nh          = i_fib_nh;
    assign o_rsp_tuser       = i_fib_tuser;
endmodule

// File: tb/tb_ipv4_fib_lookup_arb.sv
// Bench for ipv4_fib_lookup_arb: directed scenarios plus random traffic, checked every
// cycle against an issue-order queue model and a simple in-order FIB model.
module tb_ipv4_fib_lookup_arb;
    localparam int NR   = 2;
    localparam int MAXO = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR*32-1:0] i_req_daddr;
    logic [31:0]      req_addr [NR];
    logic [NR-1:0]    i_req_valid = '0;
    logic [NR-1:0]    i_rsp_rd = '0;
    logic             i_fib_nh_found = 1'b0;
    logic [31:0]      i_fib_nh = '0;
    logic [7:0]       i_fib_tuser = '0;
    logic             i_fib_valid = 1'b0;
    logic [NR-1:0]    o_req_ack;
    logic [NR-1:0]    o_rsp_valid;
    logic             o_rsp_nh_found;
    logic [31:0]      o_rsp_nh;
    logic [7:0]       o_rsp_tuser;
    logic [31:0]      o_fib_daddr;
    logic             o_fib_daddr_valid;
    logic             o_fib_rd;
    logic [2:0]       o_outstanding;
    logic             o_err_orphan;

    ipv4_fib_lookup_arb #(.NUM_REQ(NR), .REQ_BITS(1), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset(reset),
        .i_req_daddr(i_req_daddr), .i_req_valid(i_req_valid), .o_req_ack(o_req_ack),
        .o_rsp_valid(o_rsp_valid), .o_rsp_nh_found(o_rsp_nh_found), .o_rsp_nh(o_rsp_nh),
        .o_rsp_tuser(o_rsp_tuser), .i_rsp_rd(i_rsp_rd),
        .o_fib_daddr(o_fib_daddr), .o_fib_daddr_valid(o_fib_daddr_valid),
        .i_fib_nh_found(i_fib_nh_found), .i_fib_nh(i_fib_nh), .i_fib_tuser(i_fib_tuser),
        .i_fib_valid(i_fib_valid), .o_fib_rd(o_fib_rd),
        .o_outstanding(o_outstanding), .o_err_orphan(o_err_orphan)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) i_req_daddr[32*i +: 32] = req_addr[i];
    end

    // FIB contents as a pure function of the looked-up address.
    function automatic logic [31:0] nh_of(input logic [31:0] a);
        return {a[31:16], 16'h0001};
    endfunction
    function automatic logic [7:0] tuser_of(input logic [31:0] a);
        return {4'h0, a[9:8], 2'b00};
    endfunction
    function automatic logic found_of(input logic [31:0] a);
        return a[31:24] != 8'h00;
    endfunction

    int          n_checks = 0;
    int          n_err = 0;
    int          mq_tag [$];
    logic [31:0] mq_addr [$];
    int          m_ptr, m_ack;
    logic [31:0] m_daddr;
    logic        m_err;
    logic [31:0] fib_fifo [$];
    logic [31:0] stg;
    logic        stg_v;
    logic        inject_orphan = 1'b0;
    logic        auto_drive = 1'b0;
    int          n, ngr;
    int          grants [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fib();
        if (fib_fifo.size() > 0) begin
            i_fib_valid    = 1'b1;
            i_fib_nh       = nh_of(fib_fifo[0]);
            i_fib_tuser    = tuser_of(fib_fifo[0]);
            i_fib_nh_found = found_of(fib_fifo[0]);
        end else begin
            i_fib_valid    = 1'b0;
            i_fib_nh       = '0;
            i_fib_tuser    = '0;
            i_fib_nh_found = 1'b0;
        end
    endtask

    task automatic model_reset();
        mq_tag.delete();
        mq_addr.delete();
        m_ptr   = NR - 1;
        m_ack   = -1;
        m_daddr = '0;
        m_err   = 1'b0;
        fib_fifo.delete();
        stg_v   = 1'b0;
        stg     = '0;
        drive_fib();
    endtask

    task automatic drive_random();
        for (int i = 0; i < NR; i++) begin
            if (m_ack == i || !i_req_valid[i]) begin
                if ($urandom_range(0, 99) < 50) begin
                    i_req_valid[i] = 1'b1;
                    req_addr[i]    = $urandom();
                end else begin
                    i_req_valid[i] = 1'b0;
                end
            end
            i_rsp_rd[i] = ($urandom_range(0, 99) < 40);
        end
    endtask

    // One clock: check every output against the model, then advance model and FIB.
    task automatic step();
        logic [NR-1:0] exp_rv, exp_ack;
        logic          pop, orphan, dut_rd, fib_strobe;
        logic [31:0]   fib_addr, gaddr;
        int            g;
        @(negedge clk);
        exp_rv = '0;
        if (i_fib_valid && mq_tag.size() > 0) exp_rv[mq_tag[0]] = 1'b1;
        pop    = (exp_rv & i_rsp_rd) != '0;
        orphan = i_fib_valid && (mq_tag.size() == 0);
        exp_ack = '0;
        if (m_ack >= 0) exp_ack[m_ack] = 1'b1;
        chk("rsp_valid", o_rsp_valid, exp_rv);
        chk("fib_rd", o_fib_rd, pop || orphan);
        chk("rsp_nh_pass", o_rsp_nh, i_fib_nh);
        chk("rsp_tuser_pass", o_rsp_tuser, i_fib_tuser);
        chk("rsp_found_pass", o_rsp_nh_found, i_fib_nh_found);
        if (exp_rv != '0) chk("rsp_order_nh", o_rsp_nh, nh_of(mq_addr[0]));
        chk("req_ack", o_req_ack, exp_ack);
        chk("fib_strobe", o_fib_daddr_valid, m_ack >= 0);
        chk("fib_daddr", o_fib_daddr, m_daddr);
        chk("outstanding", o_outstanding, mq_tag.size());
        chk("err_orphan", o_err_orphan, m_err);
        g = -1;
        if (!reset && mq_tag.size() < MAXO) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_ptr + k) % NR;
                if (g < 0 && i_req_valid[c] && c != m_ack) g = c;
            end
        end
        gaddr      = (g >= 0) ? req_addr[g] : 32'h0;
        dut_rd     = o_fib_rd;
        fib_strobe = o_fib_daddr_valid;
        fib_addr   = o_fib_daddr;
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            if (pop) begin
                void'(mq_tag.pop_front());
                void'(mq_addr.pop_front());
            end
            if (g >= 0) begin
                mq_tag.push_back(g);
                mq_addr.push_back(gaddr);
                m_ptr   = g;
                m_daddr = gaddr;
            end
            m_ack = g;
            if (orphan) m_err = 1'b1;
            if (dut_rd && fib_fifo.size() > 0) void'(fib_fifo.pop_front());
            if (stg_v) fib_fifo.push_back(stg);
            stg_v = fib_strobe;
            stg   = fib_addr;
            if (inject_orphan) fib_fifo.push_back(32'hDEAD0105);
            drive_fib();
        end
        if (auto_drive) drive_random();
        #1;
    endtask

    task automatic reset_dut();
        reset       = 1'b1;
        i_req_valid = '0;
        i_rsp_rd    = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) req_addr[i] = '0;
        @(posedge clk);
        #1;
        model_reset();
        step();
        reset = 1'b0;
        chk("rst_ack", o_req_ack, 0);
        chk("rst_strobe", o_fib_daddr_valid, 0);
        chk("rst_daddr", o_fib_daddr, 0);
        chk("rst_outstanding", o_outstanding, 0);
        chk("rst_err", o_err_orphan, 0);

        // Single request end to end
        i_req_valid = 2'b01;
        req_addr[0] = 32'h0A000105;
        step();
        chk("t1_ack", o_req_ack, 2'b01);
        chk("t1_strobe", o_fib_daddr_valid, 1);
        chk("t1_daddr", o_fib_daddr, 32'h0A000105);
        i_req_valid = '0;
        n = 0;
        while (o_rsp_valid !== 2'b01 && n < 10) begin step(); n++; end
        chk("t1_latency", n, 2);
        chk("t1_rsp_valid", o_rsp_valid, 2'b01);
        chk("t1_nh", o_rsp_nh, 32'h0A000001);
        chk("t1_tuser", o_rsp_tuser, 8'h04);
        i_rsp_rd = 2'b01;
        #1;
        chk("t1_fib_rd", o_fib_rd, 1);
        step();
        i_rsp_rd = '0;
        #1;
        chk("t1_fib_rd_once", o_fib_rd, 0);
        chk("t1_outstanding", o_outstanding, 0);

        // Contention then credit exhaustion
        reset_dut();
        i_req_valid = 2'b11;
        req_addr[0] = $urandom();
        req_addr[1] = $urandom();
        ngr = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            for (int i = 0; i < NR; i++) begin
                if (o_req_ack[i]) begin
                    if (ngr < 8) grants[ngr] = i;
                    ngr++;
                    req_addr[i] = $urandom();
                end
            end
        end
        chk("t2_ngrants", ngr, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("t2_grant%0d", k), grants[k], k % 2);
        chk("t3_outstanding_full", o_outstanding, 4);
        step();
        step();
        chk("t3_no_ack", o_req_ack, 0);
        chk("t3_no_strobe", o_fib_daddr_valid, 0);
        chk("t3_still_full", o_outstanding, 4);
        chk("t3_head_valid", o_rsp_valid, 2'b01);
        i_rsp_rd = 2'b01;
        #1;
        chk("t3_pop_rd", o_fib_rd, 1);
        step();
        i_rsp_rd = '0;
        chk("t3_after_pop_cnt", o_outstanding, 3);
        chk("t3_after_pop_strobe", o_fib_daddr_valid, 0);
        step();
        i_req_valid = '0;
        chk("t3_fifth_strobe", o_fib_daddr_valid, 1);
        chk("t3_fifth_ack", o_req_ack, 2'b01);
        chk("t3_refull", o_outstanding, 4);

        // Ordering with head-of-line blocking
        reset_dut();
        i_req_valid = 2'b10;
        req_addr[1] = 32'hC0A80164;
        step();
        chk("t4_ack1", o_req_ack, 2'b10);
        i_req_valid = 2'b01;
        req_addr[0] = 32'h0B0C0D0E;
        step();
        chk("t4_ack0", o_req_ack, 2'b01);
        i_req_valid = '0;
        i_rsp_rd    = 2'b01;
        n = 0;
        while (o_rsp_valid !== 2'b10 && n < 10) begin step(); n++; end
        chk("t4_head_is_1", o_rsp_valid, 2'b10);
        chk("t4_early_rd_ignored", o_fib_rd, 0);
        chk("t4_nh1", o_rsp_nh, 32'hC0A80001);
        i_rsp_rd = 2'b11;
        #1;
        chk("t4_rd1", o_fib_rd, 1);
        step();
        i_rsp_rd = '0;
        #1;
        chk("t4_head_is_0", o_rsp_valid, 2'b01);
        chk("t4_nh0", o_rsp_nh, 32'h0B0C0001);
        chk("t4_tuser0", o_rsp_tuser, 8'h04);
        chk("t4_one_left", o_outstanding, 1);
        i_rsp_rd = 2'b01;
        step();
        i_rsp_rd = '0;
        chk("t4_drained", o_outstanding, 0);

        // Orphan result
        inject_orphan = 1'b1;
        step();
        inject_orphan = 1'b0;
        chk("t5_orphan_rd", o_fib_rd, 1);
        chk("t5_no_rsp", o_rsp_valid, 0);
        step();
        chk("t5_err_set", o_err_orphan, 1);
        chk("t5_rd_single", o_fib_rd, 0);
        chk("t5_cnt", o_outstanding, 0);
        repeat (3) step();
        chk("t5_err_sticky", o_err_orphan, 1);

        // Reset with lookups in flight
        i_req_valid = 2'b11;
        repeat (3) step();
        i_req_valid = '0;
        chk("t6_three_out", o_outstanding, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_cnt_cleared", o_outstanding, 0);
        chk("t6_rsp_cleared", o_rsp_valid, 0);
        chk("t6_err_cleared", o_err_orphan, 0);
        chk("t6_ack_cleared", o_req_ack, 0);
        i_req_valid = 2'b11;
        step();
        i_req_valid = '0;
        chk("t6_first_grant", o_req_ack, 2'b01);

        // Random traffic, then drain
        auto_drive = 1'b1;
        repeat (1500) step();
        auto_drive  = 1'b0;
        i_req_valid = '0;
        i_rsp_rd    = '1;
        repeat (20) step();
        chk("drain_empty", o_outstanding, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
